// File: rtl/ir_decode_queue.sv
// MIPS control decoder feeding a DEPTH-entry bundle FIFO with valid/ready handshakes, flush and async reset.
// Optional feature: define IRDEC_EXC_EN to flag illegal opcodes and block intake after a syscall/illegal bundle.
module ir_decode_queue #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ir,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [31:0]     out_ir,
  output logic [14:0]     out_ctrl,
  output logic            exc_req
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam int REG_DST   = 0;
  localparam int MEM_READ  = 1;
  localparam int MEM_WRITE = 2;
  localparam int BRANCH    = 3;
  localparam int JMP       = 4;
  localparam int REG_WRITE = 5;
  localparam int MEM_TO_REG= 6;
  localparam int ALU_SRC   = 7;
  localparam int JAL       = 11;
  localparam int JR        = 12;
  localparam int SYSCALL   = 13;
  localparam int ILLEGAL   = 14;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     ir;
    logic [14:0]     ctrl;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  entry_t        head_q, head_d, new_entry;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          out_valid_q, out_valid_d;
  logic [14:0]   dec_ctrl;
  logic [5:0]    op, func;
  logic          push, pop, blocked;

  assign op   = in_ir[31:26];
  assign func = in_ir[5:0];

  always_comb begin
    dec_ctrl = '0;
    case (op)
      6'h00: begin
        if (func == 6'h08) begin
          dec_ctrl[REG_DST] = 1'b1;
          dec_ctrl[10:8]    = 3'b111;
          dec_ctrl[JR]      = 1'b1;
        end else if (func == 6'h0C) begin
          dec_ctrl[SYSCALL] = 1'b1;
        end else begin
          dec_ctrl[REG_DST]   = 1'b1;
          dec_ctrl[REG_WRITE] = 1'b1;
          dec_ctrl[10:8]      = 3'b111;
        end
      end
      6'h23: begin
        dec_ctrl[MEM_READ]   = 1'b1;
        dec_ctrl[MEM_TO_REG] = 1'b1;
        dec_ctrl[REG_WRITE]  = 1'b1;
        dec_ctrl[ALU_SRC]    = 1'b1;
      end
      6'h2B: begin
        dec_ctrl[MEM_WRITE] = 1'b1;
        dec_ctrl[ALU_SRC]   = 1'b1;
      end
      6'h04, 6'h05: begin
        dec_ctrl[BRANCH] = 1'b1;
        dec_ctrl[10:8]   = 3'b001;
      end
      6'h02: dec_ctrl[JMP] = 1'b1;
      6'h03: begin
        dec_ctrl[JMP]       = 1'b1;
        dec_ctrl[JAL]       = 1'b1;
        dec_ctrl[REG_WRITE] = 1'b1;
      end
      6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h0F: begin
        dec_ctrl[ALU_SRC]   = 1'b1;
        dec_ctrl[REG_WRITE] = 1'b1;
        case (op)
          6'h0C:   dec_ctrl[10:8] = 3'b010;
          6'h0D:   dec_ctrl[10:8] = 3'b011;
          6'h0A:   dec_ctrl[10:8] = 3'b100;
          6'h0F:   dec_ctrl[10:8] = 3'b101;
          default: dec_ctrl[10:8] = 3'b000;
        endcase
      end
      default: begin
`ifdef IRDEC_EXC_EN
        dec_ctrl[ILLEGAL] = 1'b1;
`else
        dec_ctrl = '0;
`endif
      end
    endcase
  end

  assign new_entry = '{pc: in_pc, ir: in_ir, ctrl: dec_ctrl};
  assign in_ready  = (count_q != FULL_CNT) && !blocked;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid_q && out_ready && !flush;

  // The head register is loaded with whatever will sit at the read pointer after this edge,
  // taking the incoming bundle directly when it lands in that very slot.
  always_comb begin
    mem_d       = mem_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    head_d      = head_q;
    if (flush) begin
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_entry;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      out_valid_d = (count_d != '0);
      if (out_valid_d) begin
        head_d = (push && (wr_ptr_q == rd_ptr_d)) ? new_entry : mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      head_q      <= '0;
    end else begin
      mem_q       <= mem_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
    end
  end

`ifdef IRDEC_EXC_EN
  logic exc_req_q, exc_req_d, exc_blk_q, exc_blk_d;

  always_comb begin
    exc_req_d = push && (dec_ctrl[SYSCALL] || dec_ctrl[ILLEGAL]);
    exc_blk_d = flush ? 1'b0 : (exc_blk_q || exc_req_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_req_q <= 1'b0;
      exc_blk_q <= 1'b0;
    end else begin
      exc_req_q <= exc_req_d;
      exc_blk_q <= exc_blk_d;
    end
  end

  assign exc_req = exc_req_q;
  assign blocked = exc_blk_q;
`else
  assign exc_req = 1'b0;
  assign blocked = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign out_pc    = head_q.pc;
  assign out_ir    = head_q.ir;
  assign out_ctrl  = head_q.ctrl;

endmodule

// File: tb/tb_ir_decode_queue.sv
// Self-checking bench for ir_decode_queue: queue-level reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_ir_decode_queue;

   localparam int PC_W  = 32;
   localparam int DEPTH = 2;
`ifdef IRDEC_EXC_EN
   localparam bit EXC_EN = 1'b1;
`else
   localparam bit EXC_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_ir;
   logic [PC_W-1:0] in_pc;
   logic            flush;
   logic            out_valid;
   logic            out_ready;
   logic [PC_W-1:0] out_pc;
   logic [31:0]     out_ir;
   logic [14:0]     out_ctrl;
   logic            exc_req;

   int nCompared   = 0;
   int nMismatched = 0;

   ir_decode_queue #(.PC_W(PC_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_ir(in_ir), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir),
      .out_ctrl(out_ctrl), .exc_req(exc_req)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ir;
      logic [14:0] ctrl;
   } bundle_t;

   bundle_t mQueue[$];
   bundle_t mHead;
   bit      mExc;
   bit      mBlk;

   // Control bundle straight from the opcode table, written as whole-word constants
   function automatic logic [14:0] expCtrl(input logic [31:0] ir);
      logic [5:0] op;
      logic [5:0] fn;
      op = ir[31:26];
      fn = ir[5:0];
      case (op)
         6'h00:   expCtrl = (fn == 6'h08) ? 15'h1701 : (fn == 6'h0C) ? 15'h2000 : 15'h0721;
         6'h23:   expCtrl = 15'h00E2;
         6'h2B:   expCtrl = 15'h0084;
         6'h04,
         6'h05:   expCtrl = 15'h0108;
         6'h02:   expCtrl = 15'h0010;
         6'h03:   expCtrl = 15'h0830;
         6'h08:   expCtrl = 15'h00A0;
         6'h0C:   expCtrl = 15'h02A0;
         6'h0D:   expCtrl = 15'h03A0;
         6'h0A:   expCtrl = 15'h04A0;
         6'h0F:   expCtrl = 15'h05A0;
         default: expCtrl = EXC_EN ? 15'h4000 : 15'h0000;
      endcase
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a plain FIFO of bundles updated on each clock edge
   always @(posedge clk or posedge rst) begin : modelProc
      bit canTake;
      bit doPush;
      bit doPop;
      bundle_t b;
      if (rst) begin
         mQueue.delete();
         mHead = '{pc: '0, ir: '0, ctrl: '0};
         mExc  = 1'b0;
         mBlk  = 1'b0;
      end else begin
         canTake = (mQueue.size() < DEPTH) && !mBlk;
         doPush  = in_valid && canTake && !flush;
         doPop   = (mQueue.size() > 0) && out_ready;
         mExc    = 1'b0;
         if (flush) begin
            mQueue.delete();
            mBlk = 1'b0;
         end else begin
            if (doPop) void'(mQueue.pop_front());
            if (doPush) begin
               b = '{pc: in_pc, ir: in_ir, ctrl: expCtrl(in_ir)};
               mQueue.push_back(b);
               if (EXC_EN && (b.ctrl[13] || b.ctrl[14])) begin
                  mExc = 1'b1;
                  mBlk = 1'b1;
               end
            end
         end
         if (mQueue.size() > 0) mHead = mQueue[0];
      end
   end

   // Every falling edge outside reset, the DUT must match the model
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("cyc out_valid", out_valid, mQueue.size() > 0);
         checkOutput("cyc in_ready", in_ready, (mQueue.size() < DEPTH) && !mBlk);
         checkOutput("cyc exc_req", exc_req, mExc);
         checkOutput("cyc out_pc", out_pc, mHead.pc);
         checkOutput("cyc out_ir", out_ir, mHead.ir);
         checkOutput("cyc out_ctrl", out_ctrl, mHead.ctrl);
      end
   end

   // Drive one cycle of inputs, let the edge consume them, return just after the edge
   task automatic applyStimulus(input logic v, input logic [31:0] ir, input logic [31:0] pc,
                                input logic fl, input logic ordy);
      in_valid  = v;
      in_ir     = ir;
      in_pc     = pc;
      flush     = fl;
      out_ready = ordy;
      @(posedge clk);
      #1;
   endtask

   logic [31:0] streamIr   [10];
   logic [14:0] streamCtrl [10];

   initial begin
      streamIr   = '{32'h00221820, 32'h03E00008, 32'h10220003, 32'h14220003, 32'h08000010,
                     32'h0C000010, 32'h2021FFFF, 32'h302100FF, 32'h28210005, 32'hAC820008};
      streamCtrl = '{15'h0721, 15'h1701, 15'h0108, 15'h0108, 15'h0010,
                     15'h0830, 15'h00A0, 15'h02A0, 15'h04A0, 15'h0084};

      rst = 1'b1; in_valid = 1'b0; in_ir = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
      #3;
      checkOutput("reset out_valid", out_valid, 1'b0);
      checkOutput("reset in_ready", in_ready, 1'b1);
      checkOutput("reset out_ctrl", out_ctrl, 15'h0000);
      checkOutput("reset exc_req", exc_req, 1'b0);
      #9 rst = 1'b0;
      @(posedge clk); #1;

      // Single lw with 1-cycle latency
      applyStimulus(1'b1, 32'h8C820004, 32'h0, 1'b0, 1'b1);
      checkOutput("t1 out_valid", out_valid, 1'b1);
      checkOutput("t1 out_ctrl", out_ctrl, 15'h00E2);
      checkOutput("t1 out_ir", out_ir, 32'h8C820004);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      checkOutput("t1 drained", out_valid, 1'b0);
      checkOutput("t1 hold ctrl", out_ctrl, 15'h00E2);

      // Stall: two fill the queue, the third waits for space
      applyStimulus(1'b1, 32'h20010005, 32'h00, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h34020003, 32'h04, 1'b0, 1'b0);
      checkOutput("t2 full in_ready", in_ready, 1'b0);
      applyStimulus(1'b1, 32'h3C031234, 32'h08, 1'b0, 1'b0);
      checkOutput("t2 stalled pc", out_pc, 32'h00);
      applyStimulus(1'b1, 32'h3C031234, 32'h08, 1'b0, 1'b1);
      checkOutput("t2 second pc", out_pc, 32'h04);
      checkOutput("t2 space in_ready", in_ready, 1'b1);
      applyStimulus(1'b1, 32'h3C031234, 32'h08, 1'b0, 1'b1);
      checkOutput("t2 third pc", out_pc, 32'h08);
      checkOutput("t2 third ctrl", out_ctrl, 15'h05A0);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      checkOutput("t2 empty", out_valid, 1'b0);

      // Back-to-back stream across the decode table
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, streamIr[i], 32'h1000 + 32'(i * 4), 1'b0, 1'b1);
         checkOutput("t3 in_ready", in_ready, 1'b1);
         checkOutput("t3 out_pc", out_pc, 32'h1000 + 32'(i * 4));
         checkOutput("t3 out_ctrl", out_ctrl, streamCtrl[i]);
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);

      // Flush beats a simultaneous enqueue and dequeue
      applyStimulus(1'b1, 32'h8C820004, 32'h100, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'hAC820008, 32'h104, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h20010005, 32'h108, 1'b1, 1'b1);
      checkOutput("t4 flushed valid", out_valid, 1'b0);
      checkOutput("t4 flushed in_ready", in_ready, 1'b1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      checkOutput("t4 input dropped", out_valid, 1'b0);

      // Syscall and illegal opcode
      applyStimulus(1'b1, 32'h0000000C, 32'h200, 1'b0, 1'b1);
      checkOutput("t5 syscall ctrl", out_ctrl, 15'h2000);
      checkOutput("t5 syscall exc_req", exc_req, EXC_EN);
      checkOutput("t5 syscall in_ready", in_ready, !EXC_EN);
      applyStimulus(1'b1, 32'h20010005, 32'h204, 1'b0, 1'b1);
      checkOutput("t5 exc_req pulse end", exc_req, 1'b0);
      checkOutput("t5 blocked push", out_valid, !EXC_EN);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
      checkOutput("t5 unblocked", in_ready, 1'b1);
      applyStimulus(1'b1, 32'hFC000000, 32'h300, 1'b0, 1'b1);
      checkOutput("t5 illegal ctrl", out_ctrl, EXC_EN ? 15'h4000 : 15'h0000);
      checkOutput("t5 illegal exc_req", exc_req, EXC_EN);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);

      // Async reset between edges
      applyStimulus(1'b1, 32'h8C820004, 32'h400, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0000000C, 32'h404, 1'b0, 1'b0);
      checkOutput("t6 pre-reset exc_req", exc_req, EXC_EN);
      #2 rst = 1'b1;
      #1;
      checkOutput("t6 rst out_valid", out_valid, 1'b0);
      checkOutput("t6 rst exc_req", exc_req, 1'b0);
      checkOutput("t6 rst out_ctrl", out_ctrl, 15'h0000);
      checkOutput("t6 rst in_ready", in_ready, 1'b1);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
      checkOutput("t6 post-reset empty", out_valid, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
